onehot_serial_encoder: RTL

- Parametrised, clocked successor to the team's 8-to-3 one-hot encoder.
- Accepts an N-bit request vector, which may be one-hot, multi-hot or zero, over a valid/ready handshake.
- Emits the set bit positions as a stream of encoded indices, one per output handshake.
- Two selectable orders: fixed priority (lowest index first) or round-robin.
- Sits between interrupt/request collectors and single-index consumers.
- Replaces the legacy "x for multi-hot" output with defined serialised behaviour plus status flags.

---
 rtl/onehot_serial_encoder_pkg.sv | 36 +++
 rtl/onehot_serial_encoder_if.sv | 35 +++
 rtl/onehot_serial_encoder_rot_ffs.sv | 33 +++
 rtl/onehot_serial_encoder.sv | 135 +++++++++++++
 4 files changed

// File: rtl/onehot_serial_encoder_pkg.sv
// Shared types and helpers for the one-hot serial encoder.
// The helper functions work on a fixed maximum width so that a single
// non-parametrised package can serve every instance size. Callers
// zero-extend their operands to MAX_N bits and truncate the results.
package onehot_enc_pkg;

  // Largest request vector any instance may use.
  localparam int MAX_N  = 64;
  // Width of a popcount over MAX_N bits.
  localparam int MAX_CW = 7;

  // Controller states. IDLE accepts vectors. DRAIN streams indices.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  // Number of set bits in a (zero-extended) request vector.
  function automatic logic [MAX_CW-1:0] popcount(input logic [MAX_N-1:0] v);
    logic [MAX_CW-1:0] c;
    c = '0;
    for (int i = 0; i < MAX_N; i++) begin
      c = c + MAX_CW'(v[i]);
    end
    return c;
  endfunction

  // Advance an index by one.
  // Wraps explicitly so that non-power-of-2 sizes never reach index n.
  function automatic logic [31:0] wrap_inc(input logic [31:0] idx, input logic [31:0] n);
    logic [31:0] nxt;
    nxt = idx + 32'd1;
    return (nxt >= n) ? 32'd0 : nxt;
  endfunction

endpackage

// File: rtl/onehot_serial_encoder_if.sv
// Request-in / index-out bundle for onehot_serial_encoder.
//
// Handshake rule, for both the request side and the index side:
// - A transfer happens on a rising clock edge where valid and ready are both high.
// - A source holds valid and its payload stable until that edge.
// - Ready never depends on valid within the same cycle.
interface onehot_serial_encoder_if #(
  parameter int N = 8
);
  localparam int W = $clog2(N);

  logic [N-1:0] req_vec_i;
  logic         req_valid_i;
  logic         req_ready_o;
  logic [W-1:0] idx_o;
  logic         idx_valid_o;
  logic         idx_ready_i;
  logic         idx_last_o;
  logic         multi_o;
  logic [W:0]   cnt_o;
  logic         err_zero_o;

  // The encoder side.
  modport slave (
    input  req_vec_i, req_valid_i, idx_ready_i,
    output req_ready_o, idx_o, idx_valid_o, idx_last_o, multi_o, cnt_o, err_zero_o
  );

  // The side that supplies vectors and consumes indices.
  modport master (
    output req_vec_i, req_valid_i, idx_ready_i,
    input  req_ready_o, idx_o, idx_valid_o, idx_last_o, multi_o, cnt_o, err_zero_o
  );

endinterface

// File: rtl/onehot_serial_encoder_rot_ffs.sv
// Rotated find-first-set.
// Returns the first set bit of vec at or above ptr. If no such bit
// exists, the search wraps around and returns the lowest set bit of the
// whole vector. With ptr tied to 0 this reduces to plain
// lowest-index priority.
module rot_ffs #(
  parameter int N = 8
) (
  input  logic [N-1:0]         vec,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);
  localparam int W = $clog2(N);

  logic [N-1:0] upper;
  logic [W-1:0] idx_up;
  logic [W-1:0] idx_all;

  // Two lowest-set-bit scans: one over the bits at/above ptr, one over everything.
  always_comb begin
    upper   = vec & ({N{1'b1}} << ptr);
    idx_up  = '0;
    idx_all = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (upper[i]) idx_up  = W'(i);
      if (vec[i])   idx_all = W'(i);
    end
    any = |vec;
    idx = (|upper) ? idx_up : idx_all;
  end

endmodule

// File: rtl/onehot_serial_encoder.sv
// Clocked, parametrised successor to the 8-to-3 one-hot encoder.
//
// Operation:
// - A request vector (one-hot, multi-hot or zero) is accepted in IDLE.
// - Its set bit positions are then streamed out one index per handshake.
// - The order is lowest-first, or round-robin when RR_MODE = 1.
// - A zero vector produces a one-cycle err_zero pulse instead of a drain.
//
// Every output is a register, or a decode of the state register, so no
// input reaches an output combinationally. The next index is chosen from
// the next-state pending mask, so it is ready the cycle after the
// accept or handshake that produced it.
module onehot_serial_encoder
  import onehot_enc_pkg::*;
#(
  parameter int N       = 8,
  parameter bit RR_MODE = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  onehot_serial_encoder_if.slave     bus,
  output logic [0:0]                 state_dbg_o
);
  localparam int W = $clog2(N);

  localparam logic [0:0] S_IDLE  = IDLE;
  localparam logic [0:0] S_DRAIN = DRAIN;

  logic [0:0]   state_q, state_d;
  logic [N-1:0] pend_q, pend_d;
  logic [W-1:0] rr_q, rr_d;

  logic [W-1:0] idx_q;
  logic         idx_valid_q;
  logic         idx_last_q;
  logic         multi_q;
  logic [W:0]   cnt_q;
  logic         err_zero_q;

  logic         accept;
  logic         fire;
  logic         vec_zero;
  logic [W:0]   vec_cnt;
  logic [W:0]   pend_cnt;
  logic [W-1:0] search_ptr;
  logic [W-1:0] sel_idx;
  logic         sel_any;
  logic         drain_d;

  assign accept   = (state_q == S_IDLE) && bus.req_valid_i;
  assign fire     = idx_valid_q && bus.idx_ready_i;
  assign vec_zero = (bus.req_vec_i == '0);
  assign vec_cnt  = (W+1)'(popcount(MAX_N'(bus.req_vec_i)));
  assign pend_cnt = (W+1)'(popcount(MAX_N'(pend_d)));

  // Next state, pending mask and round-robin pointer.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    rr_d    = rr_q;
    case (state_q)
      S_IDLE: begin
        if (accept && !vec_zero) begin
          pend_d  = bus.req_vec_i;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (fire) begin
          pend_d = pend_q & ~(N'(1) << idx_q);
          if (RR_MODE) rr_d = W'(wrap_inc(32'(idx_q), 32'(N)));
          if (idx_last_q) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Fixed priority always searches from bit 0. Round-robin searches from the slot after the last grant.
  assign search_ptr = RR_MODE ? rr_d : '0;
  assign drain_d    = (state_d == S_DRAIN);

  rot_ffs #(
    .N(N)
  ) u_rot_ffs (
    .vec(pend_d),
    .ptr(search_ptr),
    .idx(sel_idx),
    .any(sel_any)
  );

  // Controller state: FSM, pending bits and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      rr_q    <= rr_d;
    end
  end

  // Registered outputs. Under backpressure the recomputed selection equals the held one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      idx_valid_q <= 1'b0;
      idx_last_q  <= 1'b0;
      multi_q     <= 1'b0;
      cnt_q       <= '0;
      err_zero_q  <= 1'b0;
    end else begin
      idx_valid_q <= drain_d && sel_any;
      idx_q       <= drain_d ? sel_idx : '0;
      idx_last_q  <= drain_d && (pend_cnt == (W+1)'(1));
      err_zero_q  <= accept && vec_zero;
      if (accept) begin
        cnt_q   <= vec_cnt;
        multi_q <= (vec_cnt > (W+1)'(1));
      end
    end
  end

  assign bus.req_ready_o = (state_q == S_IDLE);
  assign bus.idx_o       = idx_q;
  assign bus.idx_valid_o = idx_valid_q;
  assign bus.idx_last_o  = idx_last_q;
  assign bus.multi_o     = multi_q;
  assign bus.cnt_o       = cnt_q;
  assign bus.err_zero_o  = err_zero_q;
  assign state_dbg_o     = state_q;

endmodule
